// File: rtl/deque_engine.sv
// Parametrised double-ended queue over a circular buffer, driven by a 3-bit opcode strobe.
// Both end values are exposed continuously; rejected ops raise a one-cycle err pulse.
module deque_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic             apply,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] tail,
  output logic             empty,
  output logic             full,
  output logic             valid,
  output logic [CW-1:0]    count,
  output logic             err
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_CLEAR   = 3'b001;
  localparam logic [2:0] OP_PUSH_HD = 3'b010;
  localparam logic [2:0] OP_POP_HD  = 3'b011;
  localparam logic [2:0] OP_POP_TL  = 3'b100;
  localparam logic [2:0] OP_PUSH_TL = 3'b101;
  localparam logic [2:0] OP_REPL_TL = 3'b110;
  localparam logic [2:0] OP_ROTATE  = 3'b111;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    hd_q, hd_d, tl_q, tl_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    hd_m1, tl_m1;
  logic             is_empty, is_full;

  assign hd_m1    = hd_q - AW'(1);
  assign tl_m1    = tl_q - AW'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Single write port: every op that touches storage writes exactly one entry.
  always_comb begin
    hd_d    = hd_q;
    tl_d    = tl_q;
    count_d = count_q;
    err_d   = 1'b0;
    we      = 1'b0;
    waddr   = tl_q;
    wdata   = in;
    if (apply) begin
      case (op)
        OP_NOP: ;
        OP_CLEAR: begin
          hd_d    = '0;
          tl_d    = '0;
          count_d = '0;
        end
        OP_PUSH_HD: begin
          if (is_full) err_d = 1'b1;
          else begin
            hd_d    = hd_m1;
            we      = 1'b1;
            waddr   = hd_m1;
            count_d = count_q + CW'(1);
          end
        end
        OP_POP_HD: begin
          if (is_empty) err_d = 1'b1;
          else begin
            hd_d    = hd_q + AW'(1);
            count_d = count_q - CW'(1);
          end
        end
        OP_POP_TL: begin
          if (is_empty) err_d = 1'b1;
          else begin
            tl_d    = tl_m1;
            count_d = count_q - CW'(1);
          end
        end
        OP_PUSH_TL: begin
          if (is_full) err_d = 1'b1;
          else begin
            tl_d    = tl_q + AW'(1);
            we      = 1'b1;
            waddr   = tl_q;
            count_d = count_q + CW'(1);
          end
        end
        OP_REPL_TL: begin
          if (is_empty) err_d = 1'b1;
          else begin
            we    = 1'b1;
            waddr = tl_m1;
          end
        end
        OP_ROTATE: begin
          // When full hd-1 == tl-1, so this rewrites the same value: pure pointer rotation.
          if (is_empty) err_d = 1'b1;
          else begin
            we    = 1'b1;
            waddr = hd_m1;
            wdata = mem[tl_m1];
            hd_d  = hd_m1;
            tl_d  = tl_m1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd_q    <= '0;
      tl_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      hd_q    <= hd_d;
      tl_q    <= tl_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset, but a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end

  assign head  = is_empty ? '0 : mem[hd_q];
  assign tail  = is_empty ? '0 : mem[tl_m1];
  assign empty = is_empty;
  assign full  = is_full;
  assign valid = !is_empty;
  assign count = count_q;
  assign err   = err_q;
endmodule

// File: tb/tb_deque_engine.sv
// Directed bench for deque_engine: a DEPTH=8 and a DEPTH=4 instance share stimulus;
// each step checks outputs one edge later against hand-computed values.
module tb_deque_engine;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [2:0] op;
  logic       apply;

  logic [7:0] head8, tail8, head4, tail4;
  logic       empty8, full8, valid8, err8;
  logic       empty4, full4, valid4, err4;
  logic [3:0] cnt8;
  logic [2:0] cnt4;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] NOP = 3'b000, CLR = 3'b001, PSH_H = 3'b010, POP_H = 3'b011,
                         POP_T = 3'b100, PSH_T = 3'b101, REPL = 3'b110, ROT = 3'b111;

  always #5 clk = ~clk;

  deque_engine #(.WIDTH(8), .DEPTH(8)) u8 (
    .clk(clk), .rst(rst), .in(din), .op(op), .apply(apply),
    .head(head8), .tail(tail8), .empty(empty8), .full(full8),
    .valid(valid8), .count(cnt8), .err(err8)
  );

  deque_engine #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .in(din), .op(op), .apply(apply),
    .head(head4), .tail(tail4), .empty(empty4), .full(full4),
    .valid(valid4), .count(cnt4), .err(err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] d);
    apply = 1'b1;
    op    = o;
    din   = d;
    @(posedge clk);
    #1;
    apply = 1'b0;
    op    = NOP;
  endtask

  task automatic idle();
    apply = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; op = NOP; apply = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Reset state
    chk("rst_empty", 32'(empty8), 32'd1);
    chk("rst_full",  32'(full8),  32'd0);
    chk("rst_valid", 32'(valid8), 32'd0);
    chk("rst_head",  32'(head8),  32'd0);
    chk("rst_tail",  32'(tail8),  32'd0);
    chk("rst_count", 32'(cnt8),   32'd0);
    chk("rst_err",   32'(err8),   32'd0);

    // 1: basic tail pushes and pops at both ends
    do_op(PSH_T, 8'h02); chk("t1_err_a", 32'(err8), 32'd0);
    do_op(PSH_T, 8'h04); chk("t1_err_b", 32'(err8), 32'd0);
    do_op(PSH_T, 8'h01);
    chk("t1_count3", 32'(cnt8),  32'd3);
    chk("t1_head02", 32'(head8), 32'h02);
    chk("t1_tail01", 32'(tail8), 32'h01);
    do_op(POP_H, 8'h00);
    chk("t1_poph_head", 32'(head8), 32'h04);
    chk("t1_poph_tail", 32'(tail8), 32'h01);
    do_op(POP_T, 8'h00);
    chk("t1_popt_head", 32'(head8), 32'h04);
    chk("t1_popt_tail", 32'(tail8), 32'h04);
    chk("t1_popt_cnt",  32'(cnt8),  32'd1);
    do_op(PSH_T, 8'h06);
    do_op(PSH_T, 8'h25);
    chk("t1_tail25", 32'(tail8), 32'h25);
    do_op(POP_T, 8'h00);
    chk("t1_tail06", 32'(tail8), 32'h06);
    chk("t1_cnt2",   32'(cnt8),  32'd2);
    chk("t1_err",    32'(err8),  32'd0);
    do_op(REPL, 8'h99);
    chk("t1_repl_tail", 32'(tail8), 32'h99);
    chk("t1_repl_head", 32'(head8), 32'h04);
    chk("t1_repl_cnt",  32'(cnt8),  32'd2);

    // 2: DEPTH=4 fill from head, overflow rejection, drain
    do_reset();
    do_op(PSH_H, 8'hA1);
    do_op(PSH_H, 8'hA2);
    do_op(PSH_H, 8'hA3);
    do_op(PSH_H, 8'hA4);
    chk("t2_full",  32'(full4),  32'd1);
    chk("t2_empty", 32'(empty4), 32'd0);
    chk("t2_head",  32'(head4),  32'hA4);
    chk("t2_tail",  32'(tail4),  32'hA1);
    chk("t2_cnt",   32'(cnt4),   32'd4);
    do_op(PSH_T, 8'h55);
    chk("t2_ovf_err",  32'(err4),  32'd1);
    chk("t2_ovf_cnt",  32'(cnt4),  32'd4);
    chk("t2_ovf_head", 32'(head4), 32'hA4);
    chk("t2_ovf_tail", 32'(tail4), 32'hA1);
    idle();
    chk("t2_err_clear", 32'(err4), 32'd0);
    for (int i = 0; i < 4; i++) do_op(POP_H, 8'h00);
    chk("t2_drain_empty", 32'(empty4), 32'd1);
    chk("t2_drain_head",  32'(head4),  32'd0);
    chk("t2_drain_tail",  32'(tail4),  32'd0);
    chk("t2_drain_err",   32'(err4),   32'd0);

    // 3: rotate, then a full-depth rotation cycle restores order
    do_reset();
    do_op(PSH_T, 8'd1);
    do_op(PSH_T, 8'd2);
    do_op(PSH_T, 8'd3);
    do_op(ROT, 8'h00);
    chk("t3_rot_head", 32'(head8), 32'd3);
    chk("t3_rot_tail", 32'(tail8), 32'd2);
    chk("t3_rot_cnt",  32'(cnt8),  32'd3);
    for (int v = 4; v <= 8; v++) do_op(PSH_T, 8'(v));
    chk("t3_full", 32'(full8), 32'd1);
    do_op(ROT, 8'h00);
    chk("t3_frot_head", 32'(head8), 32'd8);
    chk("t3_frot_tail", 32'(tail8), 32'd7);
    chk("t3_frot_err",  32'(err8),  32'd0);
    for (int i = 1; i < 8; i++) begin
      do_op(ROT, 8'h00);
      chk("t3_rot_err", 32'(err8), 32'd0);
    end
    chk("t3_rest_head", 32'(head8), 32'd3);
    chk("t3_rest_tail", 32'(tail8), 32'd8);
    chk("t3_rest_cnt",  32'(cnt8),  32'd8);

    // 4: every rejectable op on empty pulses err back to back
    do_reset();
    do_op(POP_H, 8'h00);
    chk("t4_poph_err", 32'(err8), 32'd1);
    chk("t4_poph_cnt", 32'(cnt8), 32'd0);
    do_op(POP_T, 8'h00);
    chk("t4_popt_err", 32'(err8), 32'd1);
    do_op(REPL, 8'h11);
    chk("t4_repl_err",   32'(err8),   32'd1);
    chk("t4_repl_empty", 32'(empty8), 32'd1);
    do_op(ROT, 8'h00);
    chk("t4_rot_err", 32'(err8), 32'd1);
    chk("t4_rot_cnt", 32'(cnt8), 32'd0);
    do_op(CLR, 8'h00);
    chk("t4_clr_err",   32'(err8),   32'd0);
    chk("t4_clr_empty", 32'(empty8), 32'd1);
    do_op(PSH_T, 8'h09);
    do_op(PSH_H, 8'h0A);
    do_op(CLR, 8'h00);
    chk("t4_clr2_cnt",  32'(cnt8),  32'd0);
    chk("t4_clr2_head", 32'(head8), 32'd0);

    // 5: pointer wrap over 3*DEPTH push/pop pairs
    do_reset();
    for (int i = 0; i < 24; i++) begin
      do_op(PSH_T, 8'(8'h10 + i));
      chk("t5_tail",  32'(tail8), 32'(8'h10 + i));
      chk("t5_cnt1",  32'(cnt8),  32'd1);
      chk("t5_err_p", 32'(err8),  32'd0);
      do_op(POP_H, 8'h00);
      chk("t5_cnt0",  32'(cnt8),  32'd0);
      chk("t5_err_q", 32'(err8),  32'd0);
    end

    // 6: reset wins over a simultaneous push
    do_reset();
    do_op(PSH_T, 8'h01);
    do_op(PSH_T, 8'h02);
    do_op(PSH_T, 8'h03);
    chk("t6_pre_cnt", 32'(cnt8), 32'd3);
    rst = 1'b1; apply = 1'b1; op = PSH_T; din = 8'h33;
    @(posedge clk); #1;
    rst = 1'b0; apply = 1'b0; op = NOP;
    chk("t6_cnt",   32'(cnt8),   32'd0);
    chk("t6_empty", 32'(empty8), 32'd1);
    chk("t6_err",   32'(err8),   32'd0);
    chk("t6_head",  32'(head8),  32'd0);
    do_op(PSH_T, 8'h7E);
    chk("t6_post_head", 32'(head8), 32'h7E);
    chk("t6_post_tail", 32'(tail8), 32'h7E);
    chk("t6_post_cnt",  32'(cnt8),  32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
